stack_op_sequencer: RTL and testbench

//  Upstream controller for the 8-bit hardware stack in the multicycle datapath. Accepts one

---
 rtl/stack_op_sequencer.sv | 109 ++++++++++
 tb/tb_stack_op_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: sequences push/pop/tos strobes for one stack-machine op per start; STACK_SEQ_FLAGS_EN adds zero/carry flags
module stack_op_sequencer #(
  parameter int WORD   = 8,
  parameter int LENGTH = 64,
  parameter int DEPTHW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [WORD-1:0]   imm,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD-1:0]   result,
  output logic [DEPTHW-1:0] depth,
  output logic              zero,
  output logic              carry,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_tos,
  output logic [WORD-1:0]   stk_d_in,
  input  logic [WORD-1:0]   stk_d_out
);
  localparam logic [2:0] OP_PUSHI = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                         OP_AND = 3'd4, OP_OR = 3'd5, OP_NOT = 3'd6, OP_DUP = 3'd7;
  localparam logic [DEPTHW-1:0] CAP = DEPTHW'(LENGTH - 1);
  typedef enum logic [2:0] {IDLE, POP1, POP2, TOS, EXEC, PUSH, DONE} state_t;
  state_t state;
  logic [2:0] op_r;
  logic [WORD-1:0] imm_r, a, alu;
  logic [WORD:0] sum, dif;
  logic err_r, illegal, op_bin;
  assign op_bin = op_r inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign illegal = (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR} && depth < DEPTHW'(2)) ||
                   (opcode inside {OP_POP, OP_NOT, OP_DUP} && depth == '0) ||
                   ((opcode == OP_PUSHI || opcode == OP_DUP) && depth == CAP);
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign err      = done && err_r;
  assign stk_pop  = state == POP1 || state == POP2;
  assign stk_tos  = state == TOS;
  assign stk_push = state == PUSH;
  assign stk_d_in = op_r == OP_PUSHI ? imm_r : result;
  // In EXEC stk_d_out is B for binary ops and the sole operand otherwise.
  assign sum = {1'b0, stk_d_out} + {1'b0, a};
  assign dif = {1'b0, stk_d_out} - {1'b0, a};
  always_comb
    alu = op_r == OP_ADD ? sum[WORD-1:0] :
          op_r == OP_SUB ? dif[WORD-1:0] :
          op_r == OP_AND ? stk_d_out & a :
          op_r == OP_OR  ? stk_d_out | a :
          op_r == OP_NOT ? ~stk_d_out : stk_d_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      op_r   <= '0;
      imm_r  <= '0;
      a      <= '0;
      result <= '0;
      err_r  <= 1'b0;
      depth  <= '0;
    end else begin
      depth <= depth + DEPTHW'(stk_push) - DEPTHW'(stk_pop);
      case (state)
        IDLE: if (start) begin
          op_r  <= opcode;
          imm_r <= imm;
          err_r <= illegal;
          state <= illegal ? DONE : opcode == OP_PUSHI ? PUSH : opcode == OP_DUP ? TOS : POP1;
        end
        POP1: state <= op_bin ? POP2 : EXEC;
        POP2: begin
          a     <= stk_d_out;
          state <= EXEC;
        end
        TOS:  state <= EXEC;
        EXEC: begin
          if (!op_bin) a <= stk_d_out;
          result <= alu;
          state  <= op_r == OP_POP ? DONE : PUSH;
        end
        PUSH: begin
          if (op_r == OP_PUSHI) result <= imm_r;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef STACK_SEQ_FLAGS_EN
  logic zero_r, carry_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
    end else if (state == EXEC && op_r inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT}) begin
      zero_r  <= alu == '0;
      carry_r <= op_r == OP_ADD ? sum[WORD] : op_r == OP_SUB ? dif[WORD] : 1'b0;
    end
  assign zero  = zero_r;
  assign carry = carry_r;
`else
  logic flags_unused;
  assign flags_unused = sum[WORD] ^ dif[WORD];
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: scoreboard bench with a behavioural stack model behind the sequencer
module tb_stack_op_sequencer;
  localparam int WORD = 8, LENGTH = 64, DEPTHW = 7, CAP = LENGTH - 1;
  localparam logic [2:0] OP_PUSHI = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                         OP_AND = 3'd4, OP_OR = 3'd5, OP_NOT = 3'd6, OP_DUP = 3'd7;
  typedef struct {
    int lat;
    int stb;
    int dep;
    logic err;
    logic [7:0] res;
    logic z;
    logic c;
  } exp_t;
  logic clk = 0, rst = 0, start = 0;
  logic [2:0] opcode = 0;
  logic [7:0] imm = 0;
  logic busy, done, err, zero, carry, stk_push, stk_pop, stk_tos;
  logic [7:0] result, stk_d_in, stk_d_out;
  logic [DEPTHW-1:0] depth;
  int checks = 0, errors = 0, cyc = 0, st_cyc = 0, nstb = 0, sp = 0;
  logic [7:0] mem [LENGTH];
  logic [7:0] ms[$];
  logic [7:0] last_res = 0;
  logic last_z = 0, last_c = 0;
  exp_t sb[$];
  exp_t em;

  stack_op_sequencer #(.WORD(WORD), .LENGTH(LENGTH), .DEPTHW(DEPTHW)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .imm(imm),
    .busy(busy), .done(done), .err(err), .result(result), .depth(depth),
    .zero(zero), .carry(carry), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_tos(stk_tos), .stk_d_in(stk_d_in), .stk_d_out(stk_d_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stack: slot 0 unused, d_out registered one cycle after pop/tos.
  always @(posedge clk or posedge rst)
    if (rst) begin
      sp <= 0;
      stk_d_out <= 0;
    end else if (stk_push) begin
      if (sp < CAP) begin
        mem[sp + 1] <= stk_d_in;
        sp <= sp + 1;
      end
    end else if (stk_pop) begin
      if (sp > 0) begin
        stk_d_out <= mem[sp];
        sp <= sp - 1;
      end
    end else if (stk_tos) stk_d_out <= mem[sp];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stk_push | stk_pop | stk_tos) nstb = nstb + 1;
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        em = sb.pop_front();
        chk("latency", cyc - st_cyc, em.lat);
        chk("err", err, em.err);
        chk("result", result, em.res);
        chk("depth", depth, em.dep);
        chk("strobes", nstb, em.stb);
        chk("zero", zero, em.z);
        chk("carry", carry, em.c);
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [7:0] v, input int hold = 0);
    exp_t e;
    logic [7:0] a, b, r;
    logic [8:0] t;
    logic ill;
    int need, d;
    d = ms.size();
    need = (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) ? 2 : (op == OP_PUSHI) ? 0 : 1;
    ill = d < need || ((op == OP_PUSHI || op == OP_DUP) && d == CAP);
    r = last_res;
    e.lat = 1;
    e.stb = 0;
    if (!ill) begin
      if (op == OP_PUSHI) begin
        r = v; ms.push_back(v); e.lat = 2; e.stb = 1;
      end else if (op == OP_POP) begin
        r = ms.pop_back(); e.lat = 3; e.stb = 1;
      end else if (op == OP_DUP) begin
        r = ms[$]; ms.push_back(r); e.lat = 4; e.stb = 2;
      end else if (op == OP_NOT) begin
        a = ms.pop_back(); r = ~a; ms.push_back(r); e.lat = 4; e.stb = 2;
        last_z = r == 0; last_c = 0;
      end else begin
        a = ms.pop_back(); b = ms.pop_back(); e.lat = 5; e.stb = 3;
        last_c = 0;
        if (op == OP_ADD) begin t = {1'b0, b} + {1'b0, a}; r = t[7:0]; last_c = t[8]; end
        else if (op == OP_SUB) begin r = b - a; last_c = b < a; end
        else if (op == OP_AND) r = b & a;
        else r = b | a;
        last_z = r == 0;
        ms.push_back(r);
      end
    end
    last_res = r;
    e.err = ill;
    e.res = r;
    e.dep = ms.size();
`ifdef STACK_SEQ_FLAGS_EN
    e.z = last_z;
    e.c = last_c;
`else
    e.z = 0;
    e.c = 0;
`endif
    sb.push_back(e);
    @(negedge clk);
    opcode = op; imm = v; start = 1; nstb = 0; st_cyc = cyc;
    @(posedge clk);
    repeat (hold) begin
      @(negedge clk);
      opcode = OP_PUSHI; imm = 8'h77;
      @(posedge clk);
    end
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    ms.delete(); sb.delete();
    last_res = 0; last_z = 0; last_c = 0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_depth", depth, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
    // 1: PUSHI 5, PUSHI 3, ADD
    do_op(OP_PUSHI, 8'h05); do_op(OP_PUSHI, 8'h03); do_op(OP_ADD, 0);
    // 2: SUB with borrow
    do_reset();
    do_op(OP_PUSHI, 8'h02); do_op(OP_PUSHI, 8'h07); do_op(OP_SUB, 0);
    // 3: underflow rejections
    do_reset();
    do_op(OP_ADD, 0); do_op(OP_POP, 0); do_op(OP_NOT, 0); do_op(OP_DUP, 0);
    do_op(OP_PUSHI, 8'h11); do_op(OP_OR, 0);
    // 4: fill to capacity
    do_reset();
    for (int i = 1; i <= CAP; i++) do_op(OP_PUSHI, 8'(i));
    do_op(OP_PUSHI, 8'hEE); do_op(OP_DUP, 0); do_op(OP_POP, 0);
    // 5: DUP/ADD carry, then NOT
    do_reset();
    do_op(OP_PUSHI, 8'hFF); do_op(OP_DUP, 0); do_op(OP_ADD, 0); do_op(OP_NOT, 0);
    do_op(OP_PUSHI, 8'hF0); do_op(OP_AND, 0); do_op(OP_PUSHI, 8'h0C); do_op(OP_OR, 0);
    // 6: start held through busy and DONE is ignored
    do_reset();
    do_op(OP_PUSHI, 8'h01); do_op(OP_PUSHI, 8'h02); do_op(OP_ADD, 0, 5);
    repeat (8) @(negedge clk);
    chk("hold_depth", depth, ms.size());
    // reset while in POP2
    do_op(OP_PUSHI, 8'h04);
    @(negedge clk);
    opcode = OP_ADD; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #2 rst = 1;
    #1 chk("abort_busy", busy, 0);
    chk("abort_depth", depth, 0);
    @(negedge clk);
    rst = 0;
    ms.delete(); sb.delete();
    last_res = 0; last_z = 0; last_c = 0;
    repeat (8) @(negedge clk);
    chk("abort_result", result, 0);
    do_op(OP_PUSHI, 8'hAA);
    for (int i = 0; i < 60; i++) do_op(3'($urandom_range(0, 7)), 8'($urandom));
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
